// File: rtl/fx_burst_master_if.sv
// UART byte stream and fx bus signals for fx_burst_master.
// master = the burst master's view, slave = the environment (UART phys + fx slaves).
interface fx_burst_master_if #(
  parameter int unsigned ADDR_W = 22
);
  logic [7:0]        rx_data;
  logic              rx_vld;
  logic [7:0]        tx_data;
  logic              tx_vld;
  logic              tx_rdy;
  logic [ADDR_W-1:0] fx_waddr;
  logic              fx_wr;
  logic [7:0]        fx_data;
  logic [ADDR_W-1:0] fx_raddr;
  logic              fx_rd;
  logic [7:0]        fx_q;

  modport master (
    input  rx_data, rx_vld, tx_rdy, fx_q,
    output tx_data, tx_vld, fx_waddr, fx_wr, fx_data, fx_raddr, fx_rd
  );

  modport slave (
    output rx_data, rx_vld, tx_rdy, fx_q,
    input  tx_data, tx_vld, fx_waddr, fx_wr, fx_data, fx_raddr, fx_rd
  );
endinterface

// File: rtl/fx_burst_master.sv
// Framed UART command decoder issuing single/burst fx bus writes and reads with
// auto-incrementing address, read-data return over valid/ready and inter-byte timeout.
module fx_burst_master #(
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned ADDR_BYTES = 3,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned TIMEOUT_US = 1000
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic                 pluse_us,
  fx_burst_master_if.master    bus,
  output logic                 busy,
  output logic                 frame_err,
  output logic [7:0]           err_cnt
);

  localparam int unsigned SH_W = ADDR_BYTES * 8;
  localparam int unsigned AB_W = $clog2(ADDR_BYTES + 1);
  localparam logic [7:0]  CmdWr = 8'h57;
  localparam logic [7:0]  CmdRd = 8'h52;

  typedef enum logic [2:0] {
    StIdle, StAddr, StLen, StWdata, StRdIssue, StRdWait, StRdSend
  } state_e;

  state_e            state_q, state_d;
  logic [SH_W-1:0]   addr_q, addr_d;
  logic [AB_W-1:0]   abyte_q, abyte_d;
  logic              is_rd_q, is_rd_d;
  logic [8:0]        rem_q, rem_d;
  logic [3:0]        lat_q, lat_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_vld_q, tx_vld_d;
  logic [ADDR_W-1:0] fx_waddr_q, fx_waddr_d;
  logic              fx_wr_q, fx_wr_d;
  logic [7:0]        fx_data_q, fx_data_d;
  logic [ADDR_W-1:0] fx_raddr_q, fx_raddr_d;
  logic              fx_rd_q, fx_rd_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [ADDR_W-1:0] addr_cur, addr_inc;
  logic              tmo_active, expire;

  assign addr_cur   = addr_q[ADDR_W-1:0];
  assign addr_inc   = addr_cur + ADDR_W'(1);
  assign tmo_active = (state_q == StAddr) || (state_q == StLen) || (state_q == StWdata);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    abyte_d     = abyte_q;
    is_rd_d     = is_rd_q;
    rem_d       = rem_q;
    lat_d       = lat_q;
    tmo_d       = tmo_q;
    tx_data_d   = tx_data_q;
    tx_vld_d    = tx_vld_q;
    fx_waddr_d  = fx_waddr_q;
    fx_wr_d     = 1'b0;
    fx_data_d   = fx_data_q;
    fx_raddr_d  = fx_raddr_q;
    fx_rd_d     = 1'b0;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    expire      = 1'b0;

    // A received byte always beats a simultaneous timeout expiry.
    if (tmo_active) begin
      if (bus.rx_vld) begin
        tmo_d = '0;
      end else if (pluse_us) begin
        if (tmo_q == 16'(TIMEOUT_US - 1)) begin
          expire = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (bus.rx_vld && (bus.rx_data == CmdWr || bus.rx_data == CmdRd)) begin
          is_rd_d = (bus.rx_data == CmdRd);
          abyte_d = '0;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (bus.rx_vld) begin
          addr_d  = (addr_q << 8) | SH_W'(bus.rx_data);
          abyte_d = abyte_q + AB_W'(1);
          if (abyte_q == AB_W'(ADDR_BYTES - 1)) state_d = StLen;
        end
      end
      StLen: begin
        if (bus.rx_vld) begin
          rem_d   = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
          state_d = is_rd_q ? StRdIssue : StWdata;
        end
      end
      StWdata: begin
        if (bus.rx_vld) begin
          fx_wr_d    = 1'b1;
          fx_waddr_d = addr_cur;
          fx_data_d  = bus.rx_data;
          addr_d     = SH_W'(addr_inc);
          rem_d      = rem_q - 9'd1;
          if (rem_q == 9'd1) state_d = StIdle;
        end
      end
      StRdIssue: begin
        fx_rd_d    = 1'b1;
        fx_raddr_d = addr_cur;
        lat_d      = '0;
        state_d    = StRdWait;
      end
      StRdWait: begin
        // lat_q is 0 during the fx_rd cycle, so fx_q is valid when it reaches RD_LAT.
        if (lat_q == 4'(RD_LAT)) begin
          tx_data_d = bus.fx_q;
          tx_vld_d  = 1'b1;
          state_d   = StRdSend;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      StRdSend: begin
        if (tx_vld_q && bus.tx_rdy) begin
          tx_vld_d = 1'b0;
          addr_d   = SH_W'(addr_inc);
          rem_d    = rem_q - 9'd1;
          state_d  = (rem_q == 9'd1) ? StIdle : StRdIssue;
        end
      end
      default: state_d = StIdle;
    endcase

    if (expire) begin
      state_d     = StIdle;
      frame_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      abyte_q     <= '0;
      is_rd_q     <= 1'b0;
      rem_q       <= '0;
      lat_q       <= '0;
      tmo_q       <= '0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      fx_waddr_q  <= '0;
      fx_wr_q     <= 1'b0;
      fx_data_q   <= '0;
      fx_raddr_q  <= '0;
      fx_rd_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      abyte_q     <= abyte_d;
      is_rd_q     <= is_rd_d;
      rem_q       <= rem_d;
      lat_q       <= lat_d;
      tmo_q       <= tmo_d;
      tx_data_q   <= tx_data_d;
      tx_vld_q    <= tx_vld_d;
      fx_waddr_q  <= fx_waddr_d;
      fx_wr_q     <= fx_wr_d;
      fx_data_q   <= fx_data_d;
      fx_raddr_q  <= fx_raddr_d;
      fx_rd_q     <= fx_rd_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_vld   = tx_vld_q;
  assign bus.fx_waddr = fx_waddr_q;
  assign bus.fx_wr    = fx_wr_q;
  assign bus.fx_data  = fx_data_q;
  assign bus.fx_raddr = fx_raddr_q;
  assign bus.fx_rd    = fx_rd_q;
  assign busy         = busy_q;
  assign frame_err    = frame_err_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_fx_burst_master.sv
// Self-checking bench for fx_burst_master: frame-level model with expectation queues
// compared every cycle, plus literal pins on the directed scenarios.
module tb_fx_burst_master;

  localparam int unsigned AW  = 22;
  localparam int unsigned AB  = 3;
  localparam int unsigned TMO = 5;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       pluse_us;
  logic       busy;
  logic       frame_err;
  logic [7:0] err_cnt;

  fx_burst_master_if #(.ADDR_W(AW)) bus ();

  fx_burst_master #(
    .ADDR_W    (AW),
    .ADDR_BYTES(AB),
    .RD_LAT    (2),
    .TIMEOUT_US(TMO)
  ) dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .pluse_us (pluse_us),
    .bus      (bus),
    .busy     (busy),
    .frame_err(frame_err),
    .err_cnt  (err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // fx slave: fx_q = addr[7:0]+1 two cycles after the fx_rd cycle, junk otherwise.
  logic       p_vld = 1'b0;
  logic [7:0] p_dat = 8'h00;
  always @(posedge clk_sys) begin
    if (rst) begin
      p_vld      <= 1'b0;
      bus.fx_q   <= 8'h00;
    end else begin
      p_vld    <= bus.fx_rd;
      p_dat    <= bus.fx_raddr[7:0] + 8'd1;
      bus.fx_q <= p_vld ? p_dat : 8'hEE;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef struct {
    int          c;
    logic [21:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         wr_exp[$];
  logic [21:0] rd_exp[$];
  logic [7:0]  tx_exp[$];
  int          fe_exp[$];

  int          m_st = 0;  // 0 idle, 1 addr, 2 len, 3 write data, 4 reading
  bit          m_rd;
  int          m_ab;
  int          m_len;
  int          m_tmo;
  logic [21:0] m_addr;

  task automatic model_byte(input logic [7:0] b);
    if (m_st == 4 && tx_exp.size() == 0) m_st = 0;
    if (m_st != 4) m_tmo = 0;
    case (m_st)
      0: if (b == 8'h57 || b == 8'h52) begin
        m_rd = (b == 8'h52); m_ab = 0; m_addr = '0; m_st = 1;
      end
      1: begin
        m_addr = (m_addr << 8) | 22'(b);
        m_ab++;
        if (m_ab == AB) m_st = 2;
      end
      2: begin
        m_len = (b == 8'h00) ? 256 : int'(b);
        if (m_rd) begin
          for (int i = 0; i < m_len; i++) begin
            logic [21:0] a;
            a = m_addr + 22'(i);
            rd_exp.push_back(a);
            tx_exp.push_back(a[7:0] + 8'd1);
          end
          m_st = 4;
        end else begin
          m_st = 3;
        end
      end
      3: begin
        wr_exp.push_back('{c: cyc + 1, a: m_addr, d: b});
        m_addr = m_addr + 22'd1;
        m_len--;
        if (m_len == 0) m_st = 0;
      end
      default: ;
    endcase
  endtask

  // ---------------- compare process ----------------
  int          n_wr = 0, n_rd = 0, n_tx = 0, m_err = 0;
  logic [21:0] wlog_a[512];
  logic [7:0]  wlog_d[512];
  logic [21:0] last_raddr;
  logic [7:0]  last_tx;
  bit          prev_hold = 1'b0;
  logic [7:0]  prev_data;

  always @(negedge clk_sys) begin
    if (rst) begin
      prev_hold = 1'b0;
      m_err     = 0;
    end else begin
      chk("wr_rd_exclusive", {31'd0, bus.fx_wr & bus.fx_rd}, 32'd0);
      while (wr_exp.size() > 0 && wr_exp[0].c < cyc) begin
        chk("wr_missing_at", 32'(wr_exp[0].a), 32'hFFFF_FFFF);
        void'(wr_exp.pop_front());
      end
      if (bus.fx_wr) begin
        if (wr_exp.size() == 0) begin
          chk("wr_unexpected", 32'(bus.fx_waddr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = wr_exp.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(e.c));
          chk("wr_addr", 32'(bus.fx_waddr), 32'(e.a));
          chk("wr_data", 32'(bus.fx_data), 32'(e.d));
        end
        wlog_a[n_wr] = bus.fx_waddr;
        wlog_d[n_wr] = bus.fx_data;
        n_wr++;
      end
      if (bus.fx_rd) begin
        if (rd_exp.size() == 0) chk("rd_unexpected", 32'(bus.fx_raddr), 32'hFFFF_FFFF);
        else chk("rd_addr", 32'(bus.fx_raddr), 32'(rd_exp.pop_front()));
        last_raddr = bus.fx_raddr;
        n_rd++;
      end
      if (prev_hold) begin
        chk("tx_vld_held", {31'd0, bus.tx_vld}, 32'd1);
        chk("tx_data_held", 32'(bus.tx_data), 32'(prev_data));
      end
      if (bus.tx_vld && bus.tx_rdy) begin
        if (tx_exp.size() == 0) chk("tx_unexpected", 32'(bus.tx_data), 32'hFFFF_FFFF);
        else chk("tx_data", 32'(bus.tx_data), 32'(tx_exp.pop_front()));
        last_tx = bus.tx_data;
        n_tx++;
      end
      prev_hold = bus.tx_vld && !bus.tx_rdy;
      prev_data = bus.tx_data;
      if (fe_exp.size() > 0 && fe_exp[0] == cyc) begin
        chk("frame_err", {31'd0, frame_err}, 32'd1);
        void'(fe_exp.pop_front());
        if (m_err < 255) m_err++;
      end else begin
        chk("frame_err_idle", {31'd0, frame_err}, 32'd0);
      end
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_vld  = 1'b1;
    model_byte(b);
    step();
    bus.rx_vld  = 1'b0;
  endtask

  task automatic pulse();
    pluse_us = 1'b1;
    if (m_st >= 1 && m_st <= 3) begin
      m_tmo++;
      if (m_tmo == TMO) begin
        fe_exp.push_back(cyc + 1);
        m_st  = 0;
        m_tmo = 0;
      end
    end
    step();
    pluse_us = 1'b0;
  endtask

  task automatic wait_tx(input string nm, input int max);
    for (int i = 0; i < max && !bus.tx_vld; i++) step();
    chk(nm, {31'd0, bus.tx_vld}, 32'd1);
  endtask

  task automatic wait_idle(input string nm, input int max);
    for (int i = 0; i < max && busy; i++) step();
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int base;
    rst         = 1'b1;
    pluse_us    = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_vld  = 1'b0;
    bus.tx_rdy  = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk("rst_tx_vld", {31'd0, bus.tx_vld}, 32'd0);
    chk("rst_fx_wr", {31'd0, bus.fx_wr}, 32'd0);
    chk("rst_fx_rd", {31'd0, bus.fx_rd}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_fx_waddr", 32'(bus.fx_waddr), 32'd0);
    step();
    rst = 1'b0;
    idle(2);

    // Write burst of three.
    base = n_wr;
    send(8'h57); send(8'h00); send(8'h01); send(8'h00); send(8'h03);
    send(8'hAA); send(8'hBB); send(8'hCC);
    idle(2);
    chk("wb_count", 32'(n_wr - base), 32'd3);
    chk("wb_a0", 32'(wlog_a[base]), 32'h100);
    chk("wb_d0", 32'(wlog_d[base]), 32'hAA);
    chk("wb_a1", 32'(wlog_a[base+1]), 32'h101);
    chk("wb_d2", 32'(wlog_d[base+2]), 32'hCC);
    chk("wb_a2", 32'(wlog_a[base+2]), 32'h102);
    chk("wb_busy", {31'd0, busy}, 32'd0);

    // Read burst of two with 20 cycles of backpressure; a stray byte is ignored.
    bus.tx_rdy = 1'b0;
    send(8'h52); send(8'h00); send(8'h00); send(8'h10); send(8'h02);
    wait_tx("rd_first_vld", 40);
    chk("rd_first_data", 32'(bus.tx_data), 32'h11);
    chk("rd_first_addr", 32'(last_raddr), 32'h10);
    chk("rd_busy", {31'd0, busy}, 32'd1);
    send(8'h57);
    idle(19);
    bus.tx_rdy = 1'b1;
    for (int i = 0; i < 40 && n_tx < 2; i++) step();
    chk("rd_tx_count", 32'(n_tx), 32'd2);
    wait_idle("rd_idle", 20);
    chk("rd_count", 32'(n_rd), 32'd2);
    chk("rd_second_addr", 32'(last_raddr), 32'h11);
    chk("rd_second_data", 32'(last_tx), 32'h12);

    // Address wrap.
    base = n_wr;
    send(8'h57); send(8'h3F); send(8'hFF); send(8'hFF); send(8'h02);
    send(8'h01); send(8'h02);
    idle(2);
    chk("wrap_a0", 32'(wlog_a[base]), 32'h3FFFFF);
    chk("wrap_a1", 32'(wlog_a[base+1]), 32'h000000);

    // Inter-byte timeout then a clean single write.
    send(8'h57); send(8'h00);
    for (int i = 0; i < 6; i++) begin
      pulse();
      idle(2);
    end
    chk("tmo_err_cnt", 32'(err_cnt), 32'd1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    base = n_wr;
    send(8'h57); send(8'h00); send(8'h00); send(8'h00); send(8'h01); send(8'h55);
    idle(2);
    chk("tmo_wr_count", 32'(n_wr - base), 32'd1);
    chk("tmo_wr_addr", 32'(wlog_a[base]), 32'h0);
    chk("tmo_wr_data", 32'(wlog_d[base]), 32'h55);

    // Unknown command, then a 256-byte burst via LEN=0.
    send(8'h41);
    idle(2);
    chk("unk_busy", {31'd0, busy}, 32'd0);
    base = n_wr;
    send(8'h57); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    for (int i = 0; i < 256; i++) send(8'(i ^ 8'h5A));
    idle(2);
    chk("len0_count", 32'(n_wr - base), 32'd256);
    chk("len0_last_addr", 32'(wlog_a[base+255]), 32'hFF);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    chk("exp_wr_drained", 32'(wr_exp.size()), 32'd0);
    chk("exp_rd_drained", 32'(rd_exp.size() + tx_exp.size()), 32'd0);

    // Reset while holding read data in the send state.
    bus.tx_rdy = 1'b0;
    send(8'h52); send(8'h00); send(8'h00); send(8'h20); send(8'h03);
    wait_tx("rr_vld", 40);
    rst = 1'b1;
    #1;
    chk("rr_tx_vld", {31'd0, bus.tx_vld}, 32'd0);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    chk("rr_fx_rd", {31'd0, bus.fx_rd}, 32'd0);
    chk("rr_err_cnt", 32'(err_cnt), 32'd0);
    rd_exp.delete();
    tx_exp.delete();
    m_st = 0;
    idle(3);
    rst = 1'b0;
    idle(10);
    chk("rr_quiet_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
